// File: rtl/if_id_inst_queue_if.sv
// Handshake bundle between IF, the IF/ID instruction queue and ID.
// master: the IF/ID pipeline side driving the queue; slave: the queue itself.
interface if_id_inst_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 65
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_bus;
  logic              in_allowin;
  logic              out_valid;
  logic [DATA_W-1:0] out_bus;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, in_valid, in_bus, out_ready,
    input  in_allowin, out_valid, out_bus, count
  );

  modport slave (
    input  flush, in_valid, in_bus, out_ready,
    output in_allowin, out_valid, out_bus, count
  );
endinterface

// File: rtl/if_id_inst_queue.sv
// IF/ID decoupling FIFO for {pc, inst, adef} packets.
// Lets IF keep issuing fetches while ID stalls; a flush empties it in one cycle.
// Optional feature: define IF_ID_QUEUE_BYPASS_EN to forward a packet straight
// from in_bus to out_bus when the queue is empty (zero-cycle latency).
module if_id_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 65
) (
  input logic               clk,
  input logic               resetn,
  if_id_inst_queue_if.slave q
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [IDX_W-1:0]  widx, ridx;
  logic              empty, full;
  logic              bypass;
  logic              push, pop, pop_mem;

  assign widx  = wptr_q[IDX_W-1:0];
  assign ridx  = rptr_q[IDX_W-1:0];
  assign empty = (wptr_q == rptr_q);
  assign full  = (widx == ridx) && (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);

  assign q.count      = wptr_q - rptr_q;
  assign q.in_allowin = ~full | q.out_ready;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass    = empty & q.in_valid & ~q.flush;
  assign q.out_bus = bypass ? q.in_bus : mem_q[ridx];
`else
  assign bypass    = 1'b0;
  assign q.out_bus = mem_q[ridx];
`endif

  // A flush masks out_valid so ID never takes a packet in the flush cycle.
  assign q.out_valid = (~empty | bypass) & ~q.flush;
  assign pop         = q.out_valid & q.out_ready;
  // A bypassed packet leaves without ever touching storage or pointers.
  assign pop_mem     = pop & ~bypass;
  assign push        = q.in_valid & q.in_allowin & ~q.flush & ~(bypass & q.out_ready);

  // Next pointers: flush drops everything by catching rptr up to wptr.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (q.flush) begin
      rptr_d = wptr_q;
    end else begin
      if (push)    wptr_d = wptr_q + PTR_W'(1);
      if (pop_mem) rptr_d = rptr_q + PTR_W'(1);
    end
  end

  // Next storage contents: write the accepted packet at the write index.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[widx] = q.in_bus;
  end

  // Pointer registers; reset overrides flush.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Packet storage carries no reset; empty entries are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_if_id_inst_queue.sv
// Scoreboard bench for if_id_inst_queue: directed scenarios then random traffic,
// checked each cycle against a queue-based reference model.
module tb_if_id_inst_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 65;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  logic [DATA_W-1:0] expQ [$];

  if_id_inst_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) qif ();

  if_id_inst_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (qif.slave)
  );

  // Free-running clock; first rising edge at 5 so reset is seen immediately.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] mkPkt(input logic [31:0] pc, input logic [31:0] inst,
                                               input logic adef);
    return {pc, inst, adef};
  endfunction

  task automatic compare(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input logic rstN, input logic fl, input logic v,
                               input logic [DATA_W-1:0] bus, input logic rdy);
    @(posedge clk);
    #1;
    resetn        = rstN;
    qif.flush     = fl;
    qif.in_valid  = v;
    qif.in_bus    = bus;
    qif.out_ready = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, rdy);
  endtask

  // Directed check of the visible state in the current cycle.
  task automatic expectState(input string name, input int expCount, input logic expValid,
                             input logic expAllow);
    @(negedge clk);
    compare({name, ".count"}, DATA_W'(qif.count), DATA_W'(expCount));
    compare({name, ".out_valid"}, DATA_W'(qif.out_valid), DATA_W'(expValid));
    compare({name, ".in_allowin"}, DATA_W'(qif.in_allowin), DATA_W'(expAllow));
  endtask

  // Reference model: the queue holds exactly the packets ID has yet to see.
  task automatic checkOutput();
    int                sz;
    logic              byp;
    logic              expValid;
    logic              expAllow;
    logic              popped;
    logic              pushed;
    logic [DATA_W-1:0] expBus;
    sz  = expQ.size();
    byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
    byp = (sz == 0) && qif.in_valid && !qif.flush;
`endif
    expValid = ((sz > 0) || byp) && !qif.flush;
    expAllow = (sz < DEPTH) || qif.out_ready;
    compare("count", DATA_W'(qif.count), DATA_W'(sz));
    compare("out_valid", DATA_W'(qif.out_valid), DATA_W'(expValid));
    compare("in_allowin", DATA_W'(qif.in_allowin), DATA_W'(expAllow));
    if (expValid && qif.out_valid) begin
      expBus = byp ? qif.in_bus : expQ[0];
      compare("out_bus", qif.out_bus, expBus);
    end
    if (!resetn || qif.flush) begin
      expQ.delete();
    end else begin
      popped = expValid && qif.out_ready;
      pushed = qif.in_valid && expAllow;
      if (popped && !byp) void'(expQ.pop_front());
      if (pushed && !(byp && popped)) expQ.push_back(qif.in_bus);
    end
  endtask

  // Monitor: compares and advances the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    checkOutput();
  end

  initial begin
    errors        = 0;
    checks        = 0;
    resetn        = 1'b0;
    qif.flush     = 1'b0;
    qif.in_valid  = 1'b0;
    qif.in_bus    = '0;
    qif.out_ready = 1'b0;

    // 1: reset, three streamed packets, drain
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    expectState("reset", 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000000 + 32'(4 * i), 32'h02800000 + 32'(i), 1'b0), 1'b1);
    idle(3, 1'b1);
    expectState("drain1", 0, 1'b0, 1'b1);

    // 2: fill with ID stalled, fifth packet held until ID takes one
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000100 + 32'(4 * i), 32'h00100000 + 32'(i), 1'b0), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000110, 32'h00100004, 1'b0), 1'b0);
    expectState("full", 4, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000110, 32'h00100004, 1'b0), 1'b1);
    idle(6, 1'b1);
    expectState("drain2", 0, 1'b0, 1'b1);

    // 3: full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000200 + 32'(4 * i), 32'h00200000 + 32'(i), 1'b0), 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000300 + 32'(4 * i), 32'h00300000 + 32'(i), 1'b0), 1'b1);
      if (i == 4) expectState("pushpop_full", 4, 1'b1, 1'b1);
    end
    idle(6, 1'b1);

    // 4: flush at count 3 together with an incoming packet
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000400 + 32'(4 * i), 32'h00400000 + 32'(i), 1'b0), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, mkPkt(32'h1c00040c, 32'hdeadbeef, 1'b0), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    expectState("post_flush", 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000800, 32'h00800000, 1'b0), 1'b1);
    idle(3, 1'b1);

    // 5: address-error packet passes through untouched between neighbours
    applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000000, 32'h11111111, 1'b0), 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000002, 32'h22222222, 1'b1), 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000004, 32'h33333333, 1'b0), 1'b1);
    idle(4, 1'b1);

    // 6: reset with data queued, then reset together with flush
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000500 + 32'(4 * i), 32'h00500000 + 32'(i), 1'b0), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    expectState("reset_mid", 0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, mkPkt(32'h1c000600 + 32'(4 * i), 32'h00600000 + 32'(i), 1'b0), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, mkPkt(32'h1c000608, 32'h00600002, 1'b0), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    expectState("reset_flush", 0, 1'b0, 1'b1);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 1)),
                    mkPkt($urandom, $urandom, 1'($urandom_range(0, 1))),
                    ($urandom_range(0, 3) != 0));
    end
    idle(8, 1'b1);
    expectState("final", 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
